// File: rtl/data_sram_responder_if.sv
// SRAM-like data bus between the EXE-stage master and the data-side memory responder.
interface data_sram_responder_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data memory answering the SRAM-like bus in order with programmable latency.
// Optional build macro DATA_SRAM_RSP_RAND_STALL_EN adds LFSR-driven accept stalls and extra latency.
module data_sram_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned OUTST  = 2,
    parameter int unsigned LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  data_sram
);

    localparam int unsigned PW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int unsigned NW = $clog2(OUTST + 1);
    localparam int unsigned CW = $clog2(LAT + 4);
    localparam logic [PW-1:0] LAST_PTR = PW'(OUTST - 1);
    localparam logic [NW:0]   OUTST_N  = (NW + 1)'(OUTST);
    localparam logic [CW-1:0] CNT_BASE = CW'(LAT - 1);

    logic [31:0]   mem [0:(1 << ADDR_W) - 1];

    logic          q_is_wr [OUTST];
    logic [31:0]   q_rdata [OUTST];
    logic [CW-1:0] q_cnt   [OUTST];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] q_count;
    logic          data_ok_q;
    logic [31:0]   rdata_q;

    logic [ADDR_W-1:0] word_idx;
    logic [NW:0]       occ;
    logic              full;
    logic              addr_ok;
    logic              accept;
    logic              head_ready;
    logic [CW-1:0]     cnt_load;
    logic              unused_bits;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

`ifdef DATA_SRAM_RSP_RAND_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign addr_ok  = !reset && !full && (lfsr[1:0] != 2'b00);
    assign cnt_load = CNT_BASE + CW'(lfsr[3:2]);
`else
    assign addr_ok  = !reset && !full;
    assign cnt_load = CNT_BASE;
`endif

    assign word_idx = data_sram.data_sram_addr[ADDR_W+1:2];

    // The entry being presented on data_ok still holds its slot, so a full
    // queue cannot be refilled in the same cycle a response retires.
    assign occ        = {1'b0, q_count} + (NW + 1)'(data_ok_q);
    assign full       = (occ == OUTST_N);
    assign accept     = data_sram.data_sram_req && addr_ok;
    assign head_ready = (q_count != '0) && (q_cnt[rd_ptr] == '0);

    assign unused_bits = ^{data_sram.data_sram_size,
                           data_sram.data_sram_addr[31:ADDR_W+2],
                           data_sram.data_sram_addr[1:0]};

    always_ff @(posedge clk) begin
        if (accept && data_sram.data_sram_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_sram.data_sram_wstrb[b])
                    mem[word_idx][8*b +: 8] <= data_sram.data_sram_wdata[8*b +: 8];
            end
        end
    end

    // Read data is captured at accept, before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_is_wr[wr_ptr] <= data_sram.data_sram_wr;
            q_rdata[wr_ptr] <= mem[word_idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < OUTST; i++) begin
            if (reset)
                q_cnt[i] <= '0;
            else if (accept && (PW'(i) == wr_ptr))
                q_cnt[i] <= cnt_load;
            else if (q_cnt[i] != '0)
                q_cnt[i] <= q_cnt[i] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept)     wr_ptr <= ptr_inc(wr_ptr);
            if (head_ready) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({accept, head_ready})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            data_ok_q <= head_ready;
            rdata_q   <= (head_ready && !q_is_wr[rd_ptr]) ? q_rdata[rd_ptr] : '0;
        end
    end

    assign data_sram.data_sram_addr_ok = addr_ok;
    assign data_sram.data_sram_data_ok = data_ok_q;
    assign data_sram.data_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder against a word-array reference model.
module tb_data_sram_responder;

    localparam int ADDR_W = 10;
    localparam int OUTST  = 3;
    localparam int LAT    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder_if bus();

    data_sram_responder #(
        .ADDR_W(ADDR_W),
        .OUTST (OUTST),
        .LAT   (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_sram(bus)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        sb_q [$];
    logic [31:0] ref_mem [0:(1 << ADDR_W) - 1];
    int          last_due = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: the expected response is derived from the reference memory at
    // each observed accept; the due cycle is accept+LAT+1, one per cycle, FIFO.
    always @(negedge clk) begin : monitor
        bit          full;
        rsp_t        r;
        logic [ADDR_W-1:0] idx;
        if (cyc > 0) begin
            full = (sb_q.size() >= OUTST);
`ifdef DATA_SRAM_RSP_RAND_STALL_EN
            if (reset || full)
                check(bus.data_sram_addr_ok === 1'b0, "addr_ok_blocked",
                      {31'b0, bus.data_sram_addr_ok}, 32'h0);
`else
            check(bus.data_sram_addr_ok === (!reset && !full), "addr_ok",
                  {31'b0, bus.data_sram_addr_ok}, {31'b0, !reset && !full});
`endif
            if (bus.data_sram_data_ok === 1'b1) begin
                check(sb_q.size() != 0, "data_ok_pending", 32'(sb_q.size()), 32'h1);
                if (sb_q.size() != 0) begin
                    r = sb_q.pop_front();
                    check(bus.data_sram_rdata === r.data, "rdata", bus.data_sram_rdata, r.data);
`ifdef DATA_SRAM_RSP_RAND_STALL_EN
                    check(cyc >= r.due, "data_ok_early", 32'(cyc), 32'(r.due));
`else
                    check(cyc == r.due, "data_ok_cycle", 32'(cyc), 32'(r.due));
`endif
                end
            end else begin
                check(bus.data_sram_rdata === 32'h0, "rdata_idle", bus.data_sram_rdata, 32'h0);
`ifndef DATA_SRAM_RSP_RAND_STALL_EN
                if (sb_q.size() != 0)
                    check(sb_q[0].due > cyc, "data_ok_missing", 32'(cyc), 32'(sb_q[0].due));
`endif
            end
            if (!reset && bus.data_sram_req === 1'b1 && bus.data_sram_addr_ok === 1'b1) begin
                idx = bus.data_sram_addr[ADDR_W+1:2];
                if (bus.data_sram_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.data_sram_wstrb[b])
                            ref_mem[idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                    r.data = 32'h0;
                end else begin
                    r.data = ref_mem[idx];
                end
                r.due = (cyc + LAT + 1 > last_due + 1) ? cyc + LAT + 1 : last_due + 1;
                last_due = r.due;
                sb_q.push_back(r);
            end
            if (reset) begin
                sb_q.delete();
                last_due = 0;
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = wr;
        bus.data_sram_size  = 2'($urandom_range(0, 2));
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        bus.data_sram_wstrb = strb;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.data_sram_addr_ok === 1'b1) begin
                @(posedge clk);
                #1;
                bus.data_sram_req = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL issue_timeout: addr_ok never seen for addr %h", addr);
        @(posedge clk);
        #1;
        bus.data_sram_req = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.data_sram_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : stimulus
        int          w;
        logic [31:0] a;
        bus.data_sram_req   = 1'b1;
        bus.data_sram_wr    = 1'b0;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_wstrb = 4'h0;
        bus.data_sram_addr  = 32'h100;
        bus.data_sram_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus.data_sram_req = 1'b0;

        issue(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        idle(8);
        issue(1'b1, 32'h100, 32'h00AB0000, 4'b0100);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        issue(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        idle(8);

        for (int i = 0; i < OUTST + 2; i++) issue(1'b0, 32'h100, 32'h0, 4'h0);
        idle(10);

        issue(1'b0, 32'h100, 32'h0, 4'h0);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        do_reset(2);
        issue(1'b0, 32'h100, 32'h0, 4'h0);
        idle(8);

        for (int i = 64; i < 80; i++) issue(1'b1, 32'(i) << 2, $urandom(), 4'hF);

        for (int i = 0; i < 1000; i++) begin
            w = 64 + $urandom_range(0, 15);
            a = ($urandom() & 32'hFFFF_F000) | (32'(w) << 2);
            issue(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            if (i == 500) do_reset(2);
        end

        bus.data_sram_req = 1'b0;
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        check(sb_q.size() == 0, "drain", 32'(sb_q.size()), 32'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
